// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory stage and its SRAM controller:
//   - state_t / ST_*   : controller states (IDLE, LOW, HIGH, DONE)
//   - HW_WIDTH         : external SRAM data width (one half-word)
//   - BASE_ADDR_DEFAULT: byte address that maps onto SRAM word 0
// ---------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int unsigned HW_WIDTH          = 16;
   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

   // Plain 2-bit constants keep the encoding visible to older tools and
   // netlist readers.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOW  = 2'd1;
   localparam state_t ST_HIGH = 2'd2;
   localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// External 16-bit SRAM port of the memory stage.
//   sram_addr  : half-word address (driven by master)
//   sram_wdata : write data        (driven by master)
//   sram_we_n  : active-low write enable (driven by master)
//   sram_rdata : read data, valid while addressed (driven by slave)
// ---------------------------------------------------------------------------
interface mem_stage_if #(
   parameter int SRAM_AW = 18
);
   import mem_stage_pkg::*;

   logic [SRAM_AW-1:0]  sram_addr;
   logic [HW_WIDTH-1:0] sram_wdata;
   logic                sram_we_n;
   logic [HW_WIDTH-1:0] sram_rdata;

   modport master (
      output sram_addr,
      output sram_wdata,
      output sram_we_n,
      input  sram_rdata
   );

   modport slave (
      input  sram_addr,
      input  sram_wdata,
      input  sram_we_n,
      output sram_rdata
   );

endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Splits one 32-bit load/store into two half-word SRAM accesses (low half
// first), each held for WAIT_CYCLES cycles, and assembles read data.
//   clk, rst : clock, synchronous active-high reset
//   req, we  : start an access (sampled in IDLE); we=1 selects a write
//   addr     : byte address; BASE_ADDR maps to SRAM word 0, addr[1:0] ignored
//   wdata    : 32-bit store data (sampled with req)
//   rdata    : assembled load data, valid in DONE
//   busy     : high in LOW and HIGH
//   done     : high for the single DONE cycle
//   sram     : SRAM port (registered outputs)
// ---------------------------------------------------------------------------
module sram_ctrl
   import mem_stage_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int          SRAM_AW     = 18,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   mem_stage_if.master sram
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [SRAM_AW-2:0]  word_q;
   logic [HW_WIDTH-1:0] wdata_hi_q;
   logic                we_q;
   logic [SRAM_AW-2:0]  word_addr;
   logic                phase_end;

   // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR alias to
   // the top of the SRAM rather than being rejected.
   assign word_addr = (SRAM_AW-1)'((addr - BASE_ADDR) >> 2);
   assign phase_end = (cnt == LAST);
   assign busy      = (state == ST_LOW) || (state == ST_HIGH);
   assign done      = (state == ST_DONE);

   // NOTE: every register here uses <= so all of them sample the values
   // from before the edge; mixing in = would make ordering matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         word_q          <= '0;
         wdata_hi_q      <= '0;
         we_q            <= 1'b0;
         rdata           <= '0;
         sram.sram_addr  <= '0;
         sram.sram_wdata <= '0;
         sram.sram_we_n  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  // SRAM outputs are registered, so the low-half access is
                  // launched on the same edge that enters LOW.
                  state           <= ST_LOW;
                  cnt             <= '0;
                  word_q          <= word_addr;
                  wdata_hi_q      <= wdata[2*HW_WIDTH-1:HW_WIDTH];
                  we_q            <= we;
                  sram.sram_addr  <= {word_addr, 1'b0};
                  sram.sram_wdata <= wdata[HW_WIDTH-1:0];
                  sram.sram_we_n  <= ~we;
               end
            end
            ST_LOW: begin
               if (phase_end) begin
                  state                  <= ST_HIGH;
                  cnt                    <= '0;
                  rdata[HW_WIDTH-1:0]    <= sram.sram_rdata;
                  sram.sram_addr         <= {word_q, 1'b1};
                  sram.sram_wdata        <= wdata_hi_q;
                  sram.sram_we_n         <= ~we_q;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_HIGH: begin
               if (phase_end) begin
                  state                          <= ST_DONE;
                  cnt                            <= '0;
                  rdata[2*HW_WIDTH-1:HW_WIDTH]   <= sram.sram_rdata;
                  sram.sram_we_n                 <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               // DONE always returns to IDLE so a request still held on the
               // inputs is not executed a second time.
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the 5-stage pipeline with the MEM/WB pipeline register.
// Loads/stores run through sram_ctrl as two half-word accesses while freeze
// holds the upstream pipeline; other instructions pass with latency 1.
//   clk, rst                       : clock, synchronous active-high reset
//   wb_en, mem_read, mem_write     : controls from execute
//   alu_result, reg2, dest         : ALU result/byte address, store data, rd
//   freeze                         : combinational upstream hold
//   wb_en_out, mem_read_out,
//   alu_result_out, mem_data_out,
//   dest_out                       : MEM/WB register outputs
//   sram                           : external SRAM port
// ---------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int          SRAM_AW     = 18,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] alu_result,
   input  logic [31:0] reg2,
   input  logic [4:0]  dest,
   output logic        freeze,
   output logic        wb_en_out,
   output logic        mem_read_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] mem_data_out,
   output logic [4:0]  dest_out,
   mem_stage_if.master sram
);

   logic        req;
   logic        busy;
   logic        done;
   logic [31:0] rdata;

   assign req = mem_read | mem_write;

   sram_ctrl #(
      .BASE_ADDR   (BASE_ADDR),
      .SRAM_AW     (SRAM_AW),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_sram_ctrl (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (mem_write),
      .addr  (alu_result),
      .wdata (reg2),
      .rdata (rdata),
      .busy  (busy),
      .done  (done),
      .sram  (sram)
   );

   // Frozen while the access is in flight or a request waits in IDLE; DONE
   // releases the pipeline even though the request is still on the inputs.
   assign freeze = ~rst & (busy | (req & ~done));

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_out      <= 1'b0;
         mem_read_out   <= 1'b0;
         alu_result_out <= '0;
         mem_data_out   <= '0;
         dest_out       <= '0;
      end else if (!freeze) begin
         wb_en_out      <= wb_en;
         mem_read_out   <= mem_read;
         alu_result_out <= alu_result;
         dest_out       <= dest;
         // A read with mem_write also high is a store: load data unchanged.
         if (done && mem_read && !mem_write) begin
            mem_data_out <= rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam logic [31:0] BASE = 32'd1024;
   localparam int          AW   = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en      [2];
   logic        mem_read   [2];
   logic        mem_write  [2];
   logic [31:0] alu_result [2];
   logic [31:0] reg2       [2];
   logic [4:0]  dest       [2];
   logic        freeze         [2];
   logic        wb_en_out      [2];
   logic        mem_read_out   [2];
   logic [31:0] alu_result_out [2];
   logic [31:0] mem_data_out   [2];
   logic [4:0]  dest_out       [2];

   int n_vec = 0;
   int n_err = 0;

   // Reference state: word-level memory per DUT and expected load register.
   logic [31:0] ref_mem [int];
   logic [31:0] exp_mdo [2];

   // Per-operation SRAM trace sampled once per cycle.
   logic [AW-1:0] tr_addr [$];
   logic          tr_we   [$];
   logic [15:0]   tr_wd   [$];

   // Half-word SRAM models, one per DUT.
   logic [15:0] sram0 [0:(1<<AW)-1];
   logic [15:0] sram1 [0:(1<<AW)-1];

   mem_stage_if #(.SRAM_AW(AW)) sif0 ();
   mem_stage_if #(.SRAM_AW(AW)) sif1 ();

   always #5 clk = ~clk;

   mem_stage #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .wb_en(wb_en[0]), .mem_read(mem_read[0]),
      .mem_write(mem_write[0]), .alu_result(alu_result[0]), .reg2(reg2[0]),
      .dest(dest[0]), .freeze(freeze[0]), .wb_en_out(wb_en_out[0]),
      .mem_read_out(mem_read_out[0]), .alu_result_out(alu_result_out[0]),
      .mem_data_out(mem_data_out[0]), .dest_out(dest_out[0]), .sram(sif0)
   );

   mem_stage #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .wb_en(wb_en[1]), .mem_read(mem_read[1]),
      .mem_write(mem_write[1]), .alu_result(alu_result[1]), .reg2(reg2[1]),
      .dest(dest[1]), .freeze(freeze[1]), .wb_en_out(wb_en_out[1]),
      .mem_read_out(mem_read_out[1]), .alu_result_out(alu_result_out[1]),
      .mem_data_out(mem_data_out[1]), .dest_out(dest_out[1]), .sram(sif1)
   );

   always_ff @(posedge clk) begin
      if (!sif0.sram_we_n) sram0[sif0.sram_addr] <= sif0.sram_wdata;
      if (!sif1.sram_we_n) sram1[sif1.sram_addr] <= sif1.sram_wdata;
   end
   assign sif0.sram_rdata = sram0[sif0.sram_addr];
   assign sif1.sram_rdata = sram1[sif1.sram_addr];

   function automatic int wc(input int s);
      return (s == 0) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs(input int s);
      wb_en[s] = 1'b0; mem_read[s] = 1'b0; mem_write[s] = 1'b0;
      alu_result[s] = '0; reg2[s] = '0; dest[s] = '0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " wb_en_out"},      32'(wb_en_out[0]),    32'd0);
      check({tag, " mem_read_out"},   32'(mem_read_out[0]), 32'd0);
      check({tag, " alu_result_out"}, alu_result_out[0],    32'd0);
      check({tag, " mem_data_out"},   mem_data_out[0],      32'd0);
      check({tag, " dest_out"},       32'(dest_out[0]),     32'd0);
      check({tag, " sram_addr"},      32'(sif0.sram_addr),  32'd0);
      check({tag, " sram_wdata"},     32'(sif0.sram_wdata), 32'd0);
      check({tag, " sram_we_n"},      32'(sif0.sram_we_n),  32'd1);
   endtask

   // Apply one instruction to DUT s (called just after a rising edge) and
   // check freeze length, SRAM activity and the MEM/WB outputs.
   task automatic do_op(input int s, input string tag, input logic wb, input logic rd,
                        input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] ds);
      int          w_n;
      int          frozen;
      int          key;
      logic        mem;
      logic [16:0] wi;
      logic [AW-1:0] exp_addr;
      w_n    = wc(s);
      frozen = 0;
      mem    = rd | wr;
      wi     = 17'((a - BASE) >> 2);
      key    = s * (1 << 20) + int'(wi);
      tr_addr.delete(); tr_we.delete(); tr_wd.delete();
      wb_en[s] = wb; mem_read[s] = rd; mem_write[s] = wr;
      alu_result[s] = a; reg2[s] = d; dest[s] = ds;
      forever begin
         @(negedge clk);
         if (s == 0) begin
            tr_addr.push_back(sif0.sram_addr); tr_we.push_back(sif0.sram_we_n);
            tr_wd.push_back(sif0.sram_wdata);
         end else begin
            tr_addr.push_back(sif1.sram_addr); tr_we.push_back(sif1.sram_we_n);
            tr_wd.push_back(sif1.sram_wdata);
         end
         if (!freeze[s]) break;
         frozen++;
         if (frozen > 2 * w_n + 8) break;
         @(posedge clk); #1;
      end
      check({tag, " frozen_cycles"}, 32'(frozen), mem ? 32'(2 * w_n + 1) : 32'd0);
      if (mem && tr_we.size() == 2 * w_n + 2) begin
         check({tag, " we_n_first"}, 32'(tr_we[0]), 32'd1);
         for (int i = 1; i <= 2 * w_n; i++) begin
            exp_addr = (i <= w_n) ? {wi, 1'b0} : {wi, 1'b1};
            check($sformatf("%s addr[%0d]", tag, i), 32'(tr_addr[i]), 32'(exp_addr));
            check($sformatf("%s we_n[%0d]", tag, i), 32'(tr_we[i]), wr ? 32'd0 : 32'd1);
            if (wr)
               check($sformatf("%s wdata[%0d]", tag, i), 32'(tr_wd[i]),
                     (i <= w_n) ? 32'(d[15:0]) : 32'(d[31:16]));
         end
         check({tag, " we_n_done"}, 32'(tr_we[2 * w_n + 1]), 32'd1);
      end
      if (wr) ref_mem[key] = d;
      else if (rd) exp_mdo[s] = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
      @(posedge clk); #1;
      check({tag, " wb_en_out"},      32'(wb_en_out[s]),    32'(wb));
      check({tag, " mem_read_out"},   32'(mem_read_out[s]), 32'(rd));
      check({tag, " alu_result_out"}, alu_result_out[s],    a);
      check({tag, " dest_out"},       32'(dest_out[s]),     32'(ds));
      check({tag, " mem_data_out"},   mem_data_out[s],      exp_mdo[s]);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [16:0] wi;
      int          kind;
      exp_mdo[0] = '0; exp_mdo[1] = '0;
      clear_inputs(0); clear_inputs(1);

      // Reset with a store request present: freeze must stay low.
      rst = 1'b1;
      mem_write[0] = 1'b1; alu_result[0] = BASE; reg2[0] = 32'h1111_2222;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset freeze", 32'(freeze[0]), 32'd0);
      check_zero_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      clear_inputs(0);

      // Directed cases.
      do_op(0, "alu",      1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 5'd7);
      do_op(0, "store",    1'b0, 1'b0, 1'b1, BASE + 8, 32'hDEAD_BEEF, 5'd0);
      do_op(0, "load",     1'b1, 1'b1, 1'b0, BASE + 8, 32'h0, 5'd3);
      do_op(1, "w3_store", 1'b0, 1'b0, 1'b1, BASE + 20, 32'hCAFE_F00D, 5'd0);
      do_op(1, "w3_load",  1'b1, 1'b1, 1'b0, BASE + 20, 32'h0, 5'd9);
      do_op(0, "b2b_st1",  1'b0, 1'b0, 1'b1, BASE + 12, 32'hAAAA_5555, 5'd0);
      do_op(0, "b2b_st2",  1'b0, 1'b0, 1'b1, BASE + 16, 32'h0123_4567, 5'd0);
      do_op(0, "b2b_ld1",  1'b1, 1'b1, 1'b0, BASE + 12, 32'h0, 5'd1);
      do_op(0, "both",     1'b1, 1'b1, 1'b1, BASE + 24, 32'h7777_8888, 5'd4);
      do_op(0, "both_ld",  1'b1, 1'b1, 1'b0, BASE + 26, 32'h0, 5'd5);
      do_op(0, "wrap_st",  1'b0, 1'b0, 1'b1, BASE - 4, 32'h5A5A_A5A5, 5'd0);
      do_op(0, "wrap_ld",  1'b1, 1'b1, 1'b0, BASE - 1, 32'h0, 5'd6);
      clear_inputs(0); clear_inputs(1);

      // Randomised mix on both wait-state configurations.
      for (int s = 0; s < 2; s++) begin
         for (int n = 0; n < 50; n++) begin
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = BASE - 32'(4 * $urandom_range(1, 3));
            else a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            case (kind)
               0: do_op(s, $sformatf("rnd%0d_%0d alu", s, n), 1'($urandom), 1'b0, 1'b0,
                        $urandom, $urandom, 5'($urandom));
               1: do_op(s, $sformatf("rnd%0d_%0d ld", s, n), 1'($urandom), 1'b1, 1'b0,
                        a, $urandom, 5'($urandom));
               2: do_op(s, $sformatf("rnd%0d_%0d st", s, n), 1'($urandom), 1'b0, 1'b1,
                        a, $urandom, 5'($urandom));
               default: do_op(s, $sformatf("rnd%0d_%0d both", s, n), 1'($urandom), 1'b1,
                        1'b1, a, $urandom, 5'($urandom));
            endcase
         end
         clear_inputs(s);
      end

      // Reset during HIGH of a store on the single-wait DUT.
      a  = BASE + 64;
      wi = 17'((a - BASE) >> 2);
      wb_en[0] = 1'b1; mem_write[0] = 1'b1; alu_result[0] = a;
      reg2[0] = 32'h1357_9BDF; dest[0] = 5'd12;
      @(negedge clk);
      check("rst_mid freeze_idle", 32'(freeze[0]), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_mid addr_high", 32'(sif0.sram_addr), 32'({wi, 1'b1}));
      check("rst_mid we_n_high", 32'(sif0.sram_we_n), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_mid freeze_in_rst", 32'(freeze[0]), 32'd0);
      @(posedge clk); #1;
      check("rst_mid freeze_after", 32'(freeze[0]), 32'd0);
      check_zero_outputs("rst_mid");
      rst = 1'b0;
      clear_inputs(0);
      @(negedge clk);
      check("rst_mid freeze_released", 32'(freeze[0]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage pipeline; consumes the execute-stage results (ALU result, store value, destination, write-back/memory controls) and contains the MEM/WB pipeline register. Loads and stores go to an external 16-bit-wide SRAM as two half-word accesses, which makes each memory instruction multi-cycle. `freeze` holds the upstream pipeline stable for the duration; non-memory instructions pass through with one cycle of latency.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 1: cycles each half-word access is held; must be ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_en`, `mem_read`, `mem_write`  in  1 each  controls from execute stage.
- `alu_result`  in  32  ALU result / byte address.
- `reg2`  in  32  store data.
- `dest`  in  5  destination register.
- `freeze`  out  1  combinational; high means upstream must hold all inputs.
- `wb_en_out`, `mem_read_out`  out  1 each  registered controls to WB.
- `alu_result_out`, `mem_data_out`  out  32 each  registered ALU result and load data.
- `dest_out`  out  5  registered destination.
- `sram_addr`  out  SRAM_AW  half-word address (registered).
- `sram_wdata`  out  16  write data (registered).
- `sram_we_n`  out  1  active-low write enable (registered).
- `sram_rdata`  in  16  read data, valid while addressed.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- Word address w = ((alu_result − BASE_ADDR) mod 2^32) >> 2, truncated to SRAM_AW−1 bits; `alu_result[1:0]` is ignored. Half-word addresses are {w,0} (low half) and {w,1} (high half).
- IDLE, no request (`mem_read`=`mem_write`=0): `freeze`=0; MEM/WB register captures inputs every cycle and `mem_data_out` holds its value.
- IDLE, request: `freeze`=1; w and `reg2` are latched and the FSM moves to LOW.
- LOW: `sram_addr`={w,0}. On a write, `sram_wdata`=reg2[15:0] and `sram_we_n`=0. Lasts WAIT_CYCLES cycles. On a read, `sram_rdata` is captured into data[15:0] at the edge ending the last cycle. Then HIGH.
- HIGH: same as LOW with {w,1}, reg2[31:16] and data[31:16]. Then DONE.
- DONE: `freeze`=0; `sram_we_n`=1; MEM/WB register captures inputs, and `mem_data_out`=assembled data on reads (unchanged on writes). Next state is IDLE unconditionally; DONE does not re-trigger on the still-present request.
- `mem_read` and `mem_write` both high: treated as a write; `mem_read_out` is passed through as given.
- `sram_we_n`=1 in IDLE and DONE, and during reads.

## Timing
- Non-memory op: outputs update at the next rising edge (latency 1).
- Memory op first seen in IDLE at cycle t:
  - `freeze` is high for cycles t … t+2·WAIT_CYCLES.
  - DONE is cycle t+2·WAIT_CYCLES+1.
  - Outputs update at the edge ending DONE (latency 2·WAIT_CYCLES+2). With WAIT_CYCLES=1 that is 3 frozen cycles and 4-cycle latency.
- Back-to-back memory ops: the second op is seen in IDLE exactly one cycle after DONE.
- Reset values: all registered outputs 0 except `sram_we_n`=1; state IDLE; `freeze`=0 during and after reset.
- Reset mid-operation aborts the access; `sram_we_n`=1 from the next edge; a partial write may remain in SRAM.

## Structure
- Shared package holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - the `BASE_ADDR` default;
  - the half-word width constant (16).
- Sub-module `sram_ctrl` owns the FSM, wait counter, SRAM port and data assembly, and exposes `req`, `we`, `addr`, `wdata`, `rdata`, `busy` and `done`.
- `mem_stage` wraps `sram_ctrl`, generates `freeze`, and holds the MEM/WB register.

## Test plan
- ALU op, alu_result=0x12345678, dest=7, wb_en=1 → next edge: alu_result_out=0x12345678, dest_out=7, `freeze` never high.
- Store alu_result=1024+8, reg2=0xDEADBEEF, WAIT_CYCLES=1 → SRAM sees addr 4 with data 0xBEEF, then addr 5 with data 0xDEAD, `sram_we_n` low for exactly 2 cycles; `freeze` high for 3 cycles.
- Load of the same address after that store → `mem_data_out`=0xDEADBEEF at the edge ending DONE (4 cycles after request).
- WAIT_CYCLES=3, load → `freeze` high for 7 cycles; each half-word address held for 3 cycles.
- Two consecutive stores → second begins one cycle after first DONE; no double write of the first.
- `rst` asserted in HIGH of a store → next cycle: state IDLE, `sram_we_n`=1, `freeze`=0, all outputs 0.
